seq_magnitude_comparator: RTL and testbench
===========================================

// Module: seq_magnitude_comparator
// PURPOSE
//   Multi-cycle unsigned magnitude comparator for WIDTH-bit operands, built on comparator2bit.
//   Scans the operands two bits per cycle, MSB digit first.
//   Consumes comparator2bit's A_gt_B/A_eq_B/A_lt_B flags and stops at the first unequal digit.
//   Sits downstream of comparator2bit.
//   Valid/ready handshakes on the operand input and the result output.
// PARAMETERS
//   WIDTH   8   operand width; must be even and >= 2
//   DIGITS  WIDTH/2 (localparam)   number of 2-bit digits
// PORTS
//   clk        in   1      single clock; all state updates on its rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      operand pair a/b is presented
//   in_ready   out  1      block can accept an operand pair
//   a          in   WIDTH  operand A, unsigned
//   b          in   WIDTH  operand B, unsigned
//   out_valid  out  1      result flags are valid
//   out_ready  in   1      consumer accepts the result
//   a_gt_b     out  1      A > B
//   a_eq_b     out  1      A == B
//   a_lt_b     out  1      A < B
// BEHAVIOUR
//   Reset (rst=1 at a clk edge)
//   - state=IDLE; out_valid=0; a_gt_b=a_eq_b=a_lt_b=0.
//   - Shift registers and digit counter are cleared.
//   - in_ready = (state==IDLE) && !rst, so it reads 0 while rst is high.
//   - Reset mid-operation (SCAN or DONE): abort, no result is emitted, IDLE on the next cycle.
//   FSM states: IDLE, SCAN, DONE
//   - IDLE:
//     - in_ready=1.
//     - On in_valid: capture a/b into shift registers sa/sb and set cnt=DIGITS-1. Go to SCAN.
//   - SCAN:
//     - in_ready=0. sa[WIDTH-1:WIDTH-2] and sb[WIDTH-1:WIDTH-2] drive the comparator2bit instance.
//     - If its A_eq_B=0: register gt/lt from the instance, eq=0, go to DONE (early exit).
//     - Else if cnt==0: register eq=1, gt=lt=0, go to DONE.
//     - Else: shift sa/sb left by 2 and decrement cnt.
//   - DONE:
//     - out_valid=1; flags are one-hot and held stable.
//     - On out_ready: go to IDLE, out_valid=0 next cycle. Flags hold their last value.
//   Latency
//   - Let k = index of the first unequal digit (0 = MSB digit).
//   - out_valid rises k+1 cycles after the input handshake edge.
//   - Equal operands: out_valid rises DIGITS cycles after the handshake.
//   - Minimum cycles per operation: k+3, since IDLE must be revisited before the next accept.
//   - There is no back-to-back acceptance.
//   Boundary conditions
//   - in_valid outside IDLE is ignored; a/b are not sampled.
//   - out_ready outside DONE has no effect.
//   - out_ready held high in the cycle DONE is entered completes the handshake in that same cycle.
//   - WIDTH=2: a single SCAN cycle.
//   - All comparisons are unsigned; no sign handling.
//   - The flags are never multi-hot. All three are 0 only from reset until the first result.
// STRUCTURE
//   - Shared package seq_cmp_pkg: state encoding localparams ST_IDLE=2'd0, ST_SCAN=2'd1, ST_DONE=2'd2.
//   - Sub-module: one instance of the existing comparator2bit, fed the top digit of sa/sb.
//   - No other sub-modules.
//   - cnt width: $clog2(DIGITS), minimum 1 bit.
// TESTING (WIDTH=8 unless stated)
//   1. rst high for 2 cycles mid-idle
//      -> in_ready=0 while rst is high, out_valid=0, flags 000; in_ready=1 the cycle after release.
//   2. a=8'hC0, b=8'h40, out_ready=1
//      -> out_valid 1 cycle after accept, a_gt_b=1 (MSB digit differs).
//   3. a=8'h12, b=8'h13
//      -> out_valid 4 cycles after accept, a_lt_b=1 (LSB digit).
//   4. a=b=8'hA5
//      -> out_valid 4 cycles after accept, a_eq_b=1, gt=lt=0.
//   5. Case 2 with out_ready=0 for 5 cycles, plus a new in_valid during the wait
//      -> out_valid and flags stable, in_ready=0, new pair ignored;
//      -> on out_ready=1, IDLE next cycle and the next pair is accepted.
//   6. rst pulsed 2 cycles into SCAN of case 3
//      -> IDLE next cycle, out_valid never asserts.
//      Also: WIDTH=2, all 16 a/b pairs checked exhaustively against a reference model.

Source files
------------

// File: rtl/seq_cmp_pkg.sv
// Shared definitions for the sequential magnitude comparator slice.
// Holds the FSM state encoding and a helper for sizing the digit counter.
package seq_cmp_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // A single-digit operand still needs a 1-bit counter so the register exists.
  function automatic int cntWidth(input int digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

endpackage

// File: rtl/comparator2bit.sv
// Combinational 2-bit unsigned magnitude comparator.
// Exactly one of the three flags is high for any input pair.
module comparator2bit (
  input  logic [1:0] A,
  input  logic [1:0] B,
  output logic       A_gt_B,
  output logic       A_eq_B,
  output logic       A_lt_B
);

  assign A_gt_B = (A > B);
  assign A_eq_B = (A == B);
  assign A_lt_B = (A < B);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle unsigned magnitude comparator.
// Walks the operands two bits per cycle from the most significant digit,
// stopping at the first digit pair that differs, and returns one-hot
// gt/eq/lt flags over a valid/ready output handshake.
module seq_magnitude_comparator
  import seq_cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             a_gt_b,
  output logic             a_eq_b,
  output logic             a_lt_b
);

  localparam int DIGITS = WIDTH / 2;
  localparam int CNT_W  = cntWidth(DIGITS);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [CNT_W-1:0] r_cnt;
  logic             r_gt;
  logic             r_eq;
  logic             r_lt;

  logic             w_digGt;
  logic             w_digEq;
  logic             w_digLt;

  // The top digit of the shift registers is always the one under comparison.
  comparator2bit u_cmp (
    .A      (r_sa[WIDTH-1 -: 2]),
    .B      (r_sb[WIDTH-1 -: 2]),
    .A_gt_B (w_digGt),
    .A_eq_B (w_digEq),
    .A_lt_B (w_digLt)
  );

  assign in_ready  = (r_state == ST_IDLE) && !rst;
  assign out_valid = (r_state == ST_DONE);
  assign a_gt_b    = r_gt;
  assign a_eq_b    = r_eq;
  assign a_lt_b    = r_lt;

  // FSM: accept in IDLE, scan digits MSB-first in SCAN, hold the result in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_cnt   <= '0;
      r_gt    <= 1'b0;
      r_eq    <= 1'b0;
      r_lt    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_sa    <= a;
            r_sb    <= b;
            r_cnt   <= CNT_W'(DIGITS - 1);
            r_state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (!w_digEq) begin
            r_gt    <= w_digGt;
            r_lt    <= w_digLt;
            r_eq    <= 1'b0;
            r_state <= ST_DONE;
          end else if (r_cnt == '0) begin
            r_gt    <= 1'b0;
            r_lt    <= 1'b0;
            r_eq    <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_sa  <= r_sa << 2;
            r_sb  <= r_sb << 2;
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Scoreboard bench for seq_magnitude_comparator at WIDTH=8 and WIDTH=2.
// Stimulus pushes expected flags and latency; monitors pop on each result.
module tb_seq_magnitude_comparator;

  typedef struct {
    logic [2:0] flags;
    int         lat;
    int         acceptCycle;
  } expT;

  logic       clk = 1'b0;
  logic       rst;
  logic       inValid, outReady;
  logic [7:0] a, b;
  logic       inReady, outValid, gt, eq, lt;
  logic       inValid2, outReady2;
  logic [1:0] a2, b2;
  logic       inReady2, outValid2, gt2, eq2, lt2;

  int  cycle  = 0;
  int  checks = 0;
  int  errors = 0;
  expT q8[$];
  expT q2[$];
  logic prev8 = 1'b0;
  logic prev2 = 1'b0;

  seq_magnitude_comparator #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady),
    .a(a), .b(b), .out_valid(outValid), .out_ready(outReady),
    .a_gt_b(gt), .a_eq_b(eq), .a_lt_b(lt)
  );

  seq_magnitude_comparator #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(inValid2), .in_ready(inReady2),
    .a(a2), .b(b2), .out_valid(outValid2), .out_ready(outReady2),
    .a_gt_b(gt2), .a_eq_b(eq2), .a_lt_b(lt2)
  );

  // Free-running clock and an edge counter used for latency measurement.
  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor for the 8-bit instance: each rising out_valid consumes one expectation.
  always @(negedge clk) begin
    expT e;
    if (outValid && !prev8) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_result8: got flags %b, expected no result", {gt, eq, lt});
      end else begin
        e = q8.pop_front();
        checkOutput("flags8", 32'({gt, eq, lt}), 32'(e.flags));
        checkOutput("latency8", 32'(cycle - e.acceptCycle), 32'(e.lat));
      end
    end
    prev8 <= outValid;
  end

  // Monitor for the 2-bit instance.
  always @(negedge clk) begin
    expT e;
    if (outValid2 && !prev2) begin
      if (q2.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_result2: got flags %b, expected no result", {gt2, eq2, lt2});
      end else begin
        e = q2.pop_front();
        checkOutput("flags2", 32'({gt2, eq2, lt2}), 32'(e.flags));
        checkOutput("latency2", 32'(cycle - e.acceptCycle), 32'(e.lat));
      end
    end
    prev2 <= outValid2;
  end

  // Present one pair to the 8-bit instance for a single accepting edge.
  task automatic applyStimulus(input logic [7:0] aIn, input logic [7:0] bIn,
                               input logic [2:0] expFlags, input int lat, input bit pushExp);
    checkOutput("in_ready_idle8", 32'(inReady), 32'd1);
    a = aIn;
    b = bIn;
    inValid = 1'b1;
    @(posedge clk);
    #1;
    if (pushExp) q8.push_back('{flags: expFlags, lat: lat, acceptCycle: cycle});
    @(negedge clk);
    inValid = 1'b0;
  endtask

  // Wait (bounded) for the 8-bit result handshake, then check the return to IDLE.
  task automatic waitDone(input logic [2:0] expFlags);
    bit done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (outValid && outReady) begin
        @(posedge clk);
        @(negedge clk);
        checkOutput("valid_drop8", 32'(outValid), 32'd0);
        checkOutput("ready_back8", 32'(inReady), 32'd1);
        checkOutput("flags_hold8", 32'({gt, eq, lt}), 32'(expFlags));
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL handshake_timeout8: got no handshake, expected one within 20 cycles");
    end
  endtask

  // Hard stop in case the scheduling itself stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 200000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence for WIDTH=8 followed by the exhaustive WIDTH=2 sweep.
  initial begin
    bit done;
    rst = 1'b1; inValid = 1'b0; outReady = 1'b1; a = '0; b = '0;
    inValid2 = 1'b0; outReady2 = 1'b1; a2 = '0; b2 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset held two cycles while idle.
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checkOutput("in_ready_rst8", 32'(inReady), 32'd0);
      checkOutput("in_ready_rst2", 32'(inReady2), 32'd0);
      checkOutput("out_valid_rst8", 32'(outValid), 32'd0);
      checkOutput("flags_rst8", 32'({gt, eq, lt}), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    checkOutput("in_ready_release8", 32'(inReady), 32'd1);

    // Directed operand pairs with hand-computed flags and latency.
    applyStimulus(8'hC0, 8'h40, 3'b100, 1, 1'b1); waitDone(3'b100);
    applyStimulus(8'h12, 8'h13, 3'b001, 4, 1'b1); waitDone(3'b001);
    applyStimulus(8'hA5, 8'hA5, 3'b010, 4, 1'b1); waitDone(3'b010);
    applyStimulus(8'h3C, 8'h38, 3'b100, 3, 1'b1); waitDone(3'b100);
    applyStimulus(8'h4F, 8'h8F, 3'b001, 1, 1'b1); waitDone(3'b001);
    applyStimulus(8'hFF, 8'hFE, 3'b100, 4, 1'b1); waitDone(3'b100);

    // Back-pressure: result held, new pair ignored, then accepted after release.
    outReady = 1'b0;
    applyStimulus(8'hC0, 8'h40, 3'b100, 1, 1'b1);
    for (int i = 0; i < 10 && !outValid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checkOutput("valid_hold8", 32'(outValid), 32'd1);
      checkOutput("flags_stable8", 32'({gt, eq, lt}), 32'b100);
      checkOutput("in_ready_busy8", 32'(inReady), 32'd0);
      if (i == 1) begin
        inValid = 1'b1; a = 8'h00; b = 8'hFF;
      end else begin
        inValid = 1'b0;
      end
      @(negedge clk);
    end
    inValid = 1'b0;
    outReady = 1'b1;
    waitDone(3'b100);
    applyStimulus(8'h00, 8'hFF, 3'b001, 1, 1'b1); waitDone(3'b001);

    // Reset during SCAN aborts the operation without a result.
    applyStimulus(8'h12, 8'h13, 3'b001, 4, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("in_ready_abort8", 32'(inReady), 32'd1);
    checkOutput("flags_abort8", 32'({gt, eq, lt}), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("no_result_abort8", 32'(outValid), 32'd0);
    end
    applyStimulus(8'hA5, 8'hA4, 3'b100, 4, 1'b1); waitDone(3'b100);

    // WIDTH=2: every operand pair against a relational reference.
    for (int ai = 0; ai < 4; ai++) begin
      for (int bi = 0; bi < 4; bi++) begin
        checkOutput("in_ready_idle2", 32'(inReady2), 32'd1);
        a2 = 2'(ai);
        b2 = 2'(bi);
        inValid2 = 1'b1;
        @(posedge clk);
        #1;
        q2.push_back('{flags: {ai > bi, ai == bi, ai < bi}, lat: 1, acceptCycle: cycle});
        @(negedge clk);
        inValid2 = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
          if (outValid2 && outReady2) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("valid_drop2", 32'(outValid2), 32'd0);
            done = 1'b1;
          end else begin
            @(negedge clk);
          end
        end
        if (!done) begin
          checks++;
          errors++;
          $display("[TB] FAIL handshake_timeout2: got no handshake for a=%0d b=%0d, expected one", ai, bi);
        end
      end
    end

    repeat (2) @(negedge clk);
    checkOutput("queue8_empty", 32'(q8.size()), 32'd0);
    checkOutput("queue2_empty", 32'(q2.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
